// File: rtl/slink_pkg.sv
// Shared types and constants for the SLINK transmit MAC.
// Holds the FSM state enum, FIFO word bit indices, CRC polynomial and byte bundle.
package slink_pkg;

    localparam int SOP_BIT = 17;
    localparam int EOP_BIT = 16;

    localparam logic [15:0] CRC16_POLY = 16'h1021;

    typedef enum logic [3:0] {
        S_IDLE,
        S_WAIT,
        S_HI,
        S_LO,
        S_NEXT,
        S_CRC_H,
        S_CRC_L,
        S_GAP,
        S_DROP
    } state_e;

    typedef struct packed {
        logic       dval;
        logic       sop;
        logic       eop;
        logic [7:0] data;
    } slink_byte_t;

endpackage

// File: rtl/slink_crc16.sv
// Combinational byte-wise CRC-16 next-state function (MSB first, no reflection).
// Ports: crc_in current CRC, data_in byte to absorb, crc_out updated CRC.
module slink_crc16
    import slink_pkg::*;
(
    input  logic [15:0] crc_in,
    input  logic [7:0]  data_in,
    output logic [15:0] crc_out
);

    logic [15:0] c;

    always_comb begin
        c = crc_in ^ {data_in, 8'h00};
        for (int i = 0; i < 8; i++) begin
            c = c[15] ? ((c << 1) ^ CRC16_POLY) : (c << 1);
        end
        crc_out = c;
    end

endmodule

// File: rtl/slink_mactx.sv
// SLINK transmit MAC: pops 18-bit FIFO words, serialises bytes with CRC-16 trailer.
// Ports: tx FIFO pop/data/empty, PCS byte dval/sop/eop/data with rdy, eop/err pulses, busy.
module slink_mactx
    import slink_pkg::*;
#(
    parameter int          MAX_WORDS = 512,
    parameter int          IFG_LEN   = 12,
    parameter logic [15:0] CRC_INIT  = 16'hFFFF
) (
    input  logic        clk_125m,
    input  logic        rst_125m,
    input  logic        tx_en,
    input  logic        txfifo_mactx_empty,
    output logic        mactx_txfifo_rdreq,
    input  logic [17:0] txfifo_mactx_data,
    input  logic        pcstx_mactx_rdy,
    output logic        mactx_pcstx_dval,
    output logic        mactx_pcstx_sop,
    output logic        mactx_pcstx_eop,
    output logic [7:0]  mactx_pcstx_data,
    output logic        slink_tx_eop,
    output logic        slink_tx_err,
    output logic        tx_busy
);

    localparam int CW = $clog2(MAX_WORDS + 1);
    localparam int GW = (IFG_LEN > 1) ? $clog2(IFG_LEN) : 1;
    localparam logic [CW-1:0] MAXW = CW'(MAX_WORDS);
    localparam logic [GW-1:0] GAPL = GW'(IFG_LEN - 1);

    state_e        state_q, state_d;
    logic [16:0]   word_q, word_d;
    logic [15:0]   crc_q, crc_d, crc_nxt;
    logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
    logic [GW-1:0] gap_q, gap_d;
    logic          in_pkt_q, in_pkt_d;
    logic          first_q, first_d;
    logic          corrupt_q, corrupt_d;
    logic          pend_q, pend_d;

    logic        fifo_sop, fifo_eop, overlen;
    logic [7:0]  crc_byte;
    logic        rdreq_c, err_c, eop_c;
    slink_byte_t tx_byte;

    assign fifo_sop = txfifo_mactx_data[SOP_BIT];
    assign fifo_eop = txfifo_mactx_data[EOP_BIT];
    assign crc_byte = (state_q == S_LO) ? word_q[7:0] : word_q[15:8];
    assign cnt_inc  = cnt_q + CW'(1);
    // Word limit reached without an eop: packet is cut short and poisoned.
    assign overlen  = !word_q[EOP_BIT] && (cnt_inc == MAXW);

    slink_crc16 u_crc (
        .crc_in  (crc_q),
        .data_in (crc_byte),
        .crc_out (crc_nxt)
    );

    always_ff @(posedge clk_125m) begin
        if (!rst_125m) begin
            state_q   <= S_IDLE;
            word_q    <= '0;
            crc_q     <= CRC_INIT;
            cnt_q     <= '0;
            gap_q     <= '0;
            in_pkt_q  <= 1'b0;
            first_q   <= 1'b0;
            corrupt_q <= 1'b0;
            pend_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            word_q    <= word_d;
            crc_q     <= crc_d;
            cnt_q     <= cnt_d;
            gap_q     <= gap_d;
            in_pkt_q  <= in_pkt_d;
            first_q   <= first_d;
            corrupt_q <= corrupt_d;
            pend_q    <= pend_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        word_d    = word_q;
        crc_d     = crc_q;
        cnt_d     = cnt_q;
        gap_d     = gap_q;
        in_pkt_d  = in_pkt_q;
        first_d   = first_q;
        corrupt_d = corrupt_q;
        pend_d    = pend_q;
        unique case (state_q)
            S_IDLE: begin
                if (tx_en && !txfifo_mactx_empty) state_d = S_WAIT;
            end
            S_WAIT: begin
                word_d = txfifo_mactx_data[16:0];
                if (!in_pkt_q && !fifo_sop) begin
                    // A stray eop word already closes the bad frame.
                    state_d = fifo_eop ? S_IDLE : S_DROP;
                end else begin
                    first_d  = !in_pkt_q;
                    in_pkt_d = 1'b1;
                    state_d  = S_HI;
                end
            end
            S_HI: begin
                if (pcstx_mactx_rdy) begin
                    crc_d   = crc_nxt;
                    state_d = S_LO;
                end
            end
            S_LO: begin
                if (pcstx_mactx_rdy) begin
                    crc_d   = crc_nxt;
                    cnt_d   = cnt_inc;
                    first_d = 1'b0;
                    if (word_q[EOP_BIT]) begin
                        state_d = S_CRC_H;
                    end else if (overlen) begin
                        corrupt_d = 1'b1;
                        state_d   = S_CRC_H;
                    end else begin
                        state_d = S_NEXT;
                    end
                end
            end
            S_NEXT: begin
                if (!txfifo_mactx_empty) state_d = S_WAIT;
            end
            S_CRC_H: begin
                if (pcstx_mactx_rdy) state_d = S_CRC_L;
            end
            S_CRC_L: begin
                if (pcstx_mactx_rdy) begin
                    crc_d    = CRC_INIT;
                    cnt_d    = '0;
                    gap_d    = '0;
                    in_pkt_d = 1'b0;
                    state_d  = S_GAP;
                end
            end
            S_GAP: begin
                if (gap_q == GAPL) begin
                    gap_d     = '0;
                    corrupt_d = 1'b0;
                    state_d   = corrupt_q ? S_DROP : S_IDLE;
                end else begin
                    gap_d = gap_q + GW'(1);
                end
            end
            S_DROP: begin
                // pend_q marks the cycle the popped word is on the FIFO bus.
                if (pend_q) begin
                    pend_d = 1'b0;
                    if (fifo_eop) state_d = S_IDLE;
                end else if (!txfifo_mactx_empty) begin
                    pend_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        tx_byte = '0;
        rdreq_c = 1'b0;
        err_c   = 1'b0;
        eop_c   = 1'b0;
        unique case (state_q)
            S_IDLE: rdreq_c = tx_en && !txfifo_mactx_empty;
            S_WAIT: err_c = !in_pkt_q && !fifo_sop;
            S_HI: begin
                tx_byte.dval = 1'b1;
                tx_byte.sop  = first_q;
                tx_byte.data = word_q[15:8];
            end
            S_LO: begin
                tx_byte.dval = 1'b1;
                tx_byte.data = word_q[7:0];
                err_c        = pcstx_mactx_rdy && overlen;
            end
            S_NEXT: rdreq_c = !txfifo_mactx_empty;
            S_CRC_H: begin
                tx_byte.dval = 1'b1;
                tx_byte.data = crc_q[15:8] ^ {8{corrupt_q}};
            end
            S_CRC_L: begin
                tx_byte.dval = 1'b1;
                tx_byte.eop  = 1'b1;
                tx_byte.data = crc_q[7:0] ^ {8{corrupt_q}};
                eop_c        = pcstx_mactx_rdy;
            end
            S_DROP: rdreq_c = !pend_q && !txfifo_mactx_empty;
            default: ;
        endcase
    end

    // Input-driven outputs are forced low while reset is held.
    assign mactx_txfifo_rdreq = rdreq_c && rst_125m;
    assign slink_tx_err       = err_c && rst_125m;
    assign slink_tx_eop       = eop_c && rst_125m;
    assign mactx_pcstx_dval   = tx_byte.dval;
    assign mactx_pcstx_sop    = tx_byte.sop;
    assign mactx_pcstx_eop    = tx_byte.eop;
    assign mactx_pcstx_data   = tx_byte.data;
    assign tx_busy            = (state_q != S_IDLE);

endmodule

// File: tb/tb_slink_mactx.sv
// Directed self-checking bench for slink_mactx and slink_crc16.
// FIFO and PCS are modelled here; outputs are sampled on the falling edge.
module tb_slink_mactx;

    localparam int MAXW = 4;
    localparam int IFG  = 12;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        tx_en;
    logic        empty;
    logic        rdreq;
    logic [17:0] fdata = '0;
    logic        rdy;
    logic        dval, sop, eop;
    logic [7:0]  data;
    logic        tx_eop, tx_err, busy;

    logic [15:0] c_in, c_out;
    logic [7:0]  c_byte;

    always #4 clk = ~clk;

    slink_mactx #(
        .MAX_WORDS (MAXW),
        .IFG_LEN   (IFG),
        .CRC_INIT  (16'hFFFF)
    ) dut (
        .clk_125m           (clk),
        .rst_125m           (rst_n),
        .tx_en              (tx_en),
        .txfifo_mactx_empty (empty),
        .mactx_txfifo_rdreq (rdreq),
        .txfifo_mactx_data  (fdata),
        .pcstx_mactx_rdy    (rdy),
        .mactx_pcstx_dval   (dval),
        .mactx_pcstx_sop    (sop),
        .mactx_pcstx_eop    (eop),
        .mactx_pcstx_data   (data),
        .slink_tx_eop       (tx_eop),
        .slink_tx_err       (tx_err),
        .tx_busy            (busy)
    );

    slink_crc16 u_crc (
        .crc_in  (c_in),
        .data_in (c_byte),
        .crc_out (c_out)
    );

    int checks = 0;
    int errors = 0;

    logic [17:0] mem [0:255];
    int wr_ptr = 0;
    int rd_ptr = 0;
    bit pop_req = 1'b0;
    int rdy_mode = 0;

    assign empty = (wr_ptr == rd_ptr);

    int          cyc = 0;
    int          n = 0;
    logic [9:0]  blog [0:511];
    int          bcyc [0:511];
    int          eop_cnt = 0;
    int          err_cnt = 0;
    int          hold_bad = 0;
    int          rdreq_bad = 0;
    int          idle_rd_cyc = 0;
    bit          hold_pend = 1'b0;
    logic [10:0] hold_val = '0;

    always @(negedge clk) begin
        cyc++;
        pop_req = rdreq;
        if (rdreq && empty) rdreq_bad++;
        if (rdreq && !busy) idle_rd_cyc = cyc;
        if (hold_pend && ({dval, sop, eop, data} !== hold_val)) hold_bad++;
        hold_pend = dval && !rdy;
        hold_val  = {dval, sop, eop, data};
        if (dval && rdy && n < 512) begin
            blog[n] = {sop, eop, data};
            bcyc[n] = cyc;
            n++;
        end
        if (tx_eop) eop_cnt++;
        if (tx_err) err_cnt++;
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (pop_req) begin
                fdata = mem[rd_ptr & 255];
                rd_ptr++;
            end
        end
    end

    initial begin
        int k;
        k = 0;
        rdy = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            k++;
            rdy = (rdy_mode == 0) ? 1'b1 : ((k % 10) == 0);
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    function automatic logic [15:0] crc_step(input logic [15:0] ci, input logic [7:0] b);
        logic [15:0] c;
        logic        fb;
        c = ci;
        for (int i = 7; i >= 0; i--) begin
            fb = c[15] ^ b[i];
            c  = {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
        end
        return c;
    endfunction

    task automatic push(input logic [17:0] w);
        mem[wr_ptr & 255] = w;
        wr_ptr++;
    endtask

    task automatic start_tx();
        @(posedge clk);
        #1;
        tx_en = 1'b1;
    endtask

    task automatic wait_done(input int lim, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < lim; i++) begin
            @(negedge clk);
            if (!busy && empty) begin
                ok = 1'b1;
                break;
            end
        end
        @(posedge clk);
        #1;
        tx_en = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if ({rdreq, dval, sop, eop, data, tx_eop, tx_err} !== 14'h0) begin
            errors++;
            $display("FAIL reset_outputs got %h required 0",
                     {rdreq, dval, sop, eop, data, tx_eop, tx_err});
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_busy got %b required 0", busy);
        end
    endtask

    task automatic test_crc_unit();
        logic [7:0] s [9];
        logic [15:0] c;
        s = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
        c = 16'hFFFF;
        for (int i = 0; i < 9; i++) begin
            c_in   = c;
            c_byte = s[i];
            #1;
            c = c_out;
        end
        checks++;
        if (c !== 16'h29B1) begin
            errors++;
            $display("FAIL crc_123456789 got %h required 29b1", c);
        end
    endtask

    task automatic test_basic(input string tag);
        int b0, e0, r0;
        bit ok;
        logic [15:0] c;
        logic [9:0] exp [6];
        b0 = n; e0 = eop_cnt; r0 = err_cnt;
        c = 16'hFFFF;
        c = crc_step(c, 8'h31); c = crc_step(c, 8'h32);
        c = crc_step(c, 8'h33); c = crc_step(c, 8'h34);
        exp = '{{2'b10, 8'h31}, {2'b00, 8'h32}, {2'b00, 8'h33},
                {2'b00, 8'h34}, {2'b00, c[15:8]}, {2'b01, c[7:0]}};
        push(18'h2_3132);
        push(18'h1_3334);
        start_tx();
        wait_done(200, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s_done busy=%b required idle", tag, busy);
        end
        checks++;
        if (n - b0 !== 6) begin
            errors++;
            $display("FAIL %s_count got %0d required 6", tag, n - b0);
        end
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (blog[b0 + i] !== exp[i]) begin
                errors++;
                $display("FAIL %s_byte%0d got %h required %h", tag, i, blog[b0 + i], exp[i]);
            end
        end
        checks++;
        if (bcyc[b0] - idle_rd_cyc !== 2) begin
            errors++;
            $display("FAIL %s_latency got %0d required 2", tag, bcyc[b0] - idle_rd_cyc);
        end
        checks++;
        if (eop_cnt - e0 !== 1 || err_cnt - r0 !== 0) begin
            errors++;
            $display("FAIL %s_pulses eop %0d err %0d required 1 0",
                     tag, eop_cnt - e0, err_cnt - r0);
        end
    endtask

    task automatic test_stall();
        int b0, h0;
        bit ok;
        logic [15:0] c;
        logic [9:0] exp [6];
        b0 = n; h0 = hold_bad;
        c = 16'hFFFF;
        c = crc_step(c, 8'h31); c = crc_step(c, 8'h32);
        c = crc_step(c, 8'h33); c = crc_step(c, 8'h34);
        exp = '{{2'b10, 8'h31}, {2'b00, 8'h32}, {2'b00, 8'h33},
                {2'b00, 8'h34}, {2'b00, c[15:8]}, {2'b01, c[7:0]}};
        rdy_mode = 1;
        push(18'h2_3132);
        push(18'h1_3334);
        start_tx();
        wait_done(600, ok);
        rdy_mode = 0;
        checks++;
        if (!ok || n - b0 !== 6) begin
            errors++;
            $display("FAIL stall_count got %0d done %b required 6 1", n - b0, ok);
        end
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (blog[b0 + i] !== exp[i]) begin
                errors++;
                $display("FAIL stall_byte%0d got %h required %h", i, blog[b0 + i], exp[i]);
            end
        end
        checks++;
        if (hold_bad - h0 !== 0) begin
            errors++;
            $display("FAIL stall_hold got %0d unstable cycles required 0", hold_bad - h0);
        end
    endtask

    task automatic test_back_to_back();
        int b0, e0, gap;
        bit ok;
        logic [15:0] c;
        logic [9:0] exp [4];
        b0 = n; e0 = eop_cnt;
        c = crc_step(crc_step(16'hFFFF, 8'h55), 8'h66);
        exp = '{{2'b10, 8'h55}, {2'b00, 8'h66}, {2'b00, c[15:8]}, {2'b01, c[7:0]}};
        push(18'h2_3132);
        push(18'h1_3334);
        push(18'h3_5566);
        start_tx();
        wait_done(300, ok);
        checks++;
        if (!ok || n - b0 !== 10) begin
            errors++;
            $display("FAIL b2b_count got %0d done %b required 10 1", n - b0, ok);
        end
        gap = bcyc[b0 + 6] - bcyc[b0 + 5] - 1;
        checks++;
        if (gap < IFG) begin
            errors++;
            $display("FAIL b2b_gap got %0d idle cycles required >= %0d", gap, IFG);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (blog[b0 + 6 + i] !== exp[i]) begin
                errors++;
                $display("FAIL b2b_pkt2_byte%0d got %h required %h", i, blog[b0 + 6 + i], exp[i]);
            end
        end
        checks++;
        if (eop_cnt - e0 !== 2) begin
            errors++;
            $display("FAIL b2b_eop got %0d required 2", eop_cnt - e0);
        end
    endtask

    task automatic test_drop();
        int b0, r0, e0;
        bit ok;
        logic [15:0] c;
        b0 = n; r0 = err_cnt; e0 = eop_cnt;
        c = 16'hFFFF;
        c = crc_step(c, 8'h31); c = crc_step(c, 8'h32);
        c = crc_step(c, 8'h33); c = crc_step(c, 8'h34);
        push(18'h0_AAAA);
        push(18'h1_BBBB);
        push(18'h2_3132);
        push(18'h1_3334);
        start_tx();
        wait_done(300, ok);
        checks++;
        if (err_cnt - r0 !== 1) begin
            errors++;
            $display("FAIL drop_err got %0d required 1", err_cnt - r0);
        end
        checks++;
        if (!ok || n - b0 !== 6) begin
            errors++;
            $display("FAIL drop_count got %0d done %b required 6 1", n - b0, ok);
        end
        checks++;
        if (blog[b0] !== {2'b10, 8'h31}) begin
            errors++;
            $display("FAIL drop_first got %h required 231", blog[b0]);
        end
        checks++;
        if (blog[b0 + 5] !== {2'b01, c[7:0]}) begin
            errors++;
            $display("FAIL drop_last got %h required %h", blog[b0 + 5], {2'b01, c[7:0]});
        end
        checks++;
        if (eop_cnt - e0 !== 1) begin
            errors++;
            $display("FAIL drop_eop got %0d required 1", eop_cnt - e0);
        end
    endtask

    task automatic test_overlen();
        int b0, r0, e0;
        bit ok;
        logic [15:0] c;
        logic [9:0] exp [10];
        b0 = n; r0 = err_cnt; e0 = eop_cnt;
        c = 16'hFFFF;
        for (int i = 1; i <= 8; i++) c = crc_step(c, 8'(i));
        c = ~c;
        for (int i = 0; i < 8; i++) exp[i] = {(i == 0), 1'b0, 8'(i + 1)};
        exp[8] = {2'b00, c[15:8]};
        exp[9] = {2'b01, c[7:0]};
        push(18'h2_0102);
        push(18'h0_0304);
        push(18'h0_0506);
        push(18'h0_0708);
        push(18'h0_090A);
        push(18'h1_0B0C);
        start_tx();
        wait_done(400, ok);
        checks++;
        if (!ok || n - b0 !== 10) begin
            errors++;
            $display("FAIL ovl_count got %0d done %b required 10 1", n - b0, ok);
        end
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (blog[b0 + i] !== exp[i]) begin
                errors++;
                $display("FAIL ovl_byte%0d got %h required %h", i, blog[b0 + i], exp[i]);
            end
        end
        checks++;
        if (err_cnt - r0 !== 1 || eop_cnt - e0 !== 1) begin
            errors++;
            $display("FAIL ovl_pulses err %0d eop %0d required 1 1",
                     err_cnt - r0, eop_cnt - e0);
        end
    endtask

    task automatic test_reset_mid();
        int e0;
        bit seen;
        e0 = eop_cnt;
        seen = 1'b0;
        push(18'h2_1111);
        push(18'h1_2222);
        start_tx();
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (dval) begin
                seen = 1'b1;
                break;
            end
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL rstmid_start dval got 0 required 1");
        end
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if ({rdreq, dval, sop, eop, data, tx_eop, tx_err} !== 14'h0) begin
            errors++;
            $display("FAIL rstmid_outputs got %h required 0",
                     {rdreq, dval, sop, eop, data, tx_eop, tx_err});
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_busy got %b required 0", busy);
        end
        @(posedge clk);
        #1;
        tx_en  = 1'b0;
        wr_ptr = rd_ptr;
        rst_n  = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (eop_cnt - e0 !== 0) begin
            errors++;
            $display("FAIL rstmid_eop got %0d required 0", eop_cnt - e0);
        end
    endtask

    initial begin
        rst_n  = 1'b0;
        tx_en  = 1'b0;
        c_in   = '0;
        c_byte = '0;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        test_crc_unit();
        test_basic("basic");
        test_stall();
        test_back_to_back();
        test_drop();
        test_overlen();
        test_reset_mid();
        test_basic("recover");
        checks++;
        if (rdreq_bad !== 0) begin
            errors++;
            $display("FAIL rdreq_on_empty got %0d required 0", rdreq_bad);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
